// File: rtl/dimc_result_collector_if.sv
// Result stream from the DIMC collector to the Spatz vector write-back path.
// Valid/ready handshake carrying a 32-bit word and its valid-nibble count.
interface dimc_result_collector_if;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [3:0]  out_nib_o;

    modport master (output out_valid_o, output out_data_o, output out_nib_o, input out_ready_i);
    modport slave  (input out_valid_o, input out_data_o, input out_nib_o, output out_ready_i);
endinterface

// File: rtl/dimc_result_collector.sv
// Collects DIMC macro results: packs 4-bit quantised nibbles or forwards raw
// 24-bit partial sums, buffered in a show-ahead FIFO towards the vector unit.
module dimc_result_collector #(
    parameter int FIFO_DEPTH = 4,
    parameter int NIB_MAX    = 8
) (
    input  logic                 RCK,
    input  logic                 RESETn,
    input  logic                 READYN_i,
    input  logic [23:0]          PSOUT_i,
    input  logic                 SOUT_i,
    input  logic [2:0]           RES_OUT_i,
    input  logic                 cfg_raw_i,
    input  logic [3:0]           cfg_count_i,
    input  logic                 flush_i,
    input  logic                 clear_i,
    dimc_result_collector_if.master out,
    output logic                 full_o,
    output logic                 overflow_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_FILL = CW'(FIFO_DEPTH);

    function automatic logic [3:0] norm_count(input logic [3:0] c);
        if (c == 4'd0 || 32'(c) > NIB_MAX) return 4'(NIB_MAX);
        return c;
    endfunction

    function automatic logic signed [31:0] sext_psum(input logic signed [23:0] p);
        return {{8{p[23]}}, p};
    endfunction

    logic               capture;
    logic [3:0]         nibble;
    logic signed [23:0] psum;
    logic [3:0]         cnt, cnt_inc, cnt_next;
    logic [31:0]        word, word_fill, word_next;
    logic               raw_lat, eff_raw;
    logic [3:0]         count_lat, eff_count;
    logic               push;
    logic [31:0]        push_data;
    logic [3:0]         push_nib;

    logic [31:0]        mem_data [FIFO_DEPTH];
    logic [3:0]         mem_nib  [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      fill;
    logic               valid, pop, accept;

    // Packer: an empty counter means the next result or flush picks up fresh config
    always_comb begin
        capture   = !READYN_i;
        nibble    = {RES_OUT_i, SOUT_i};
        psum      = PSOUT_i;
        eff_raw   = (cnt == 4'd0) ? cfg_raw_i : raw_lat;
        eff_count = (cnt == 4'd0) ? norm_count(cfg_count_i) : count_lat;
        word_fill = word;
        if (capture && !eff_raw) word_fill[{cnt[2:0], 2'b00} +: 4] = nibble;
        cnt_inc   = cnt + {3'd0, capture};
        push      = 1'b0;
        push_data = word_fill;
        push_nib  = cnt_inc;
        cnt_next  = cnt_inc;
        word_next = word_fill;
        if (eff_raw) begin
            push      = capture;
            push_data = sext_psum(psum);
            push_nib  = 4'd1;
            cnt_next  = 4'd0;
            word_next = '0;
        end else if ((capture && cnt_inc == eff_count) || (flush_i && cnt_inc != 4'd0)) begin
            // A nibble that completes the word together with flush yields a single push
            push      = 1'b1;
            cnt_next  = 4'd0;
            word_next = '0;
        end
    end

    always_ff @(posedge RCK or negedge RESETn) begin
        if (!RESETn) begin
            cnt       <= '0;
            word      <= '0;
            raw_lat   <= 1'b0;
            count_lat <= '0;
        end else if (clear_i) begin
            cnt       <= '0;
            word      <= '0;
            raw_lat   <= 1'b0;
            count_lat <= '0;
        end else begin
            cnt  <= cnt_next;
            word <= word_next;
            if (cnt == 4'd0 && (capture || flush_i)) begin
                raw_lat   <= cfg_raw_i;
                count_lat <= norm_count(cfg_count_i);
            end
        end
    end

    // Output FIFO: a full FIFO still takes a word when the head leaves on the same edge
    always_comb begin
        valid  = (fill != '0);
        full_o = (fill == FULL_FILL);
        pop    = valid && out.out_ready_i;
        accept = push && (!full_o || pop);
    end

    always_ff @(posedge RCK) begin
        if (accept && !clear_i) begin
            mem_data[wr_ptr] <= push_data;
            mem_nib[wr_ptr]  <= push_nib;
        end
    end

    always_ff @(posedge RCK or negedge RESETn) begin
        if (!RESETn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            fill <= fill + CW'(accept) - CW'(pop);
            if (push && !accept) overflow_o <= 1'b1;
        end
    end

    assign out.out_valid_o = valid;
    assign out.out_data_o  = valid ? mem_data[rd_ptr] : 32'd0;
    assign out.out_nib_o   = valid ? mem_nib[rd_ptr]  : 4'd0;

endmodule

// File: doc/dimc_result_collector.md
Name: dimc_result_collector

Overview:
- Downstream consumer of the DIMC macro output port (READYN, PSOUT, SOUT, RES_OUT); captures each valid result in the cycle it appears.
- Packed mode: packs 4-bit ReLU-quantised results into 32-bit words for the Spatz vector register write-back path.
- Raw mode: forwards the 24-bit pre-ReLU partial sums, sign-extended to 32 bits.
- Output is buffered in a small show-ahead FIFO with a valid/ready handshake, so vector-side stalls do not lose results.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit output entries; power of two, at least 2.
- NIB_MAX, 8, maximum nibbles per packed word; fixed by the 32-bit output width.

Ports:
- RCK  in  1  clock; the only clock.
- RESETn  in  1  asynchronous active-low reset.
- READYN_i  in  1  DIMC result valid, active-low; one result per low cycle.
- PSOUT_i  in  24  DIMC pre-ReLU sum, two's complement.
- SOUT_i  in  1  DIMC result bit 0.
- RES_OUT_i  in  3  DIMC result bits 3:1.
- cfg_raw_i  in  1  1 = raw psum mode, 0 = packed nibble mode.
- cfg_count_i  in  4  nibbles per packed word, 1..8; value 0 or >8 is treated as 8.
- flush_i  in  1  push the partially filled packed word.
- clear_i  in  1  synchronous clear of packer, FIFO and overflow flag.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  consumer accepts the head.
- out_data_o  out  32  FIFO head data.
- out_nib_o  out  4  valid nibbles in the head word; 1 in raw mode.
- full_o  out  1  FIFO full.
- overflow_o  out  1  sticky: a word was dropped.

Behaviour:
- Reset (RESETn low, asynchronous):
  - packer register, nibble counter, latched cfg and FIFO pointers/count all cleared.
  - out_valid_o=0, out_data_o=0, out_nib_o=0, full_o=0, overflow_o=0.
- Capture: a result is taken on every RCK rising edge where READYN_i==0. Nibble = {RES_OUT_i, SOUT_i}.
- Config latch:
  - cfg_raw_i and cfg_count_i are latched when the nibble counter is 0 and a result or flush arrives.
  - Config changes while a word is partly filled take effect only on the next word.
- Packed mode:
  - Nibble k (0-based arrival order) is placed at bits [4k+3:4k]; unused bits are 0.
  - When a captured nibble makes the count equal the latched cfg_count, the completed word is pushed on the same edge, with out_nib_o = cfg_count. The counter returns to 0.
  - Latency: last nibble captured at edge N; out_valid_o is high after edge N if the FIFO was empty.
- Raw mode:
  - Every captured result pushes {{8{PSOUT_i[23]}}, PSOUT_i} on the same edge, with out_nib_o = 1.
  - The nibble counter is unused and stays 0.
- Flush:
  - If the counter is >0, the partial word is pushed with out_nib_o = counter, and the counter is cleared.
  - With flush_i and a captured result on the same edge, the nibble is inserted first and then pushed. If that nibble completes the word, only one push occurs.
  - Flush with counter 0 and no result: no-op.
- FIFO:
  - Show-ahead; out_data_o and out_nib_o reflect the head whenever out_valid_o=1.
  - A pop occurs when out_valid_o and out_ready_i are both high.
  - full_o is high when count == FIFO_DEPTH.
  - Push when full is accepted only if a pop occurs on the same edge; the count is unchanged.
  - Simultaneous push and pop when empty: the pushed word becomes the head next cycle; no bypass.
- Overflow:
  - A push that cannot be accepted drops the word and sets overflow_o, which stays high until clear_i or reset.
  - The packer still resets its counter, so the next word starts cleanly.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH.
- clear_i:
  - Has priority over capture, flush and pop on the same edge.
  - All state returns to reset values; a result presented on that edge is discarded.
- Implicit packer states: EMPTY (counter 0) and FILLING (counter 1..cfg_count-1). EMPTY goes to FILLING on a captured nibble when cfg_count>1; FILLING goes to EMPTY on word completion, flush or clear.

Test Plan:
- Packed, cfg_count=8, eight results with nibbles 1..8, out_ready=1 -> one word 0x87654321, out_nib=8, out_valid high for 1 cycle after the 8th edge.
- Packed, cfg_count=8, three nibbles A,B,C then flush_i -> word 0x00000CBA, out_nib=3. A following flush alone -> no push.
- Raw mode, PSOUT=0xFFFFF6 then 0x00000F -> words 0xFFFFFFF6 and 0x0000000F, out_nib=1 each.
- out_ready=0, cfg_count=1, 5 results with FIFO_DEPTH=4 -> full_o after the 4th; the 5th is dropped and overflow_o=1. Draining returns the first four in order; overflow_o stays 1 until clear_i.
- FIFO full, push and pop on the same edge -> count stays 4, no overflow, and the data order is preserved across pointer wrap.
- Assert RESETn low with 5 nibbles packed and 2 FIFO entries -> outputs zero immediately. After release, 8 new nibbles produce a word containing only the new data.
